// File: rtl/imm_pkg.sv
`default_nettype none
// imm_pkg -- immediate classes, opcode constants and skid-buffer state encodings
// Rev 1.0
package imm_pkg;

  localparam int DEPTH = 2;

  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_SIGN   = 3'd1,
    KIND_ZERO   = 3'd2,
    KIND_UPPER  = 3'd3,
    KIND_BRANCH = 3'd4
  } imm_kind_e;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] imm;
    imm_kind_e   kind;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode_ext.sv
`default_nettype none
// imm_decode_ext -- combinational opcode classification and immediate extension
// Rev 1.0
module imm_decode_ext
  import imm_pkg::*;
(
  input  logic [31:0] Instruction,
  output entry_t      entry_o
);

  logic [5:0]  opcode;
  logic [15:0] imm;

  assign opcode = Instruction[31:26];
  assign imm    = Instruction[15:0];

  always_comb begin
    entry_o = '{imm: 32'h0, kind: KIND_NONE};
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: begin
        entry_o.kind = KIND_SIGN;
        entry_o.imm  = {{16{imm[15]}}, imm};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        entry_o.kind = KIND_ZERO;
        entry_o.imm  = {16'h0, imm};
      end
      OP_LUI: begin
        entry_o.kind = KIND_UPPER;
        entry_o.imm  = {imm, 16'h0};
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        entry_o.kind = KIND_BRANCH;
        entry_o.imm  = {{14{imm[15]}}, imm, 2'b00};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_ext_sched.sv
`default_nettype none
// imm_ext_sched -- ID-stage immediate extender feeding a two-entry FIFO skid buffer
// Rev 1.0
module imm_ext_sched
  import imm_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Flush,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] Instruction,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Imm_out,
  output logic [2:0]  Imm_kind
);

  state_e state_q, state_d;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t dec_entry;
  logic   push, pop;

  imm_decode_ext u_decode (
    .Instruction (Instruction),
    .entry_o     (dec_entry)
  );

  // Handshake outputs depend on registered state only.
  assign In_ready  = (state_q != ST_TWO);
  assign Out_valid = (state_q != ST_EMPTY);
  assign Imm_out   = ent_q[0].imm;
  assign Imm_kind  = ent_q[0].kind;

  assign push = In_valid && In_ready;
  assign pop  = Out_valid && Out_ready;

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d  = ST_ONE;
            ent_d[0] = dec_entry;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            ent_d[0] = dec_entry;
          end else if (push) begin
            state_d  = ST_TWO;
            ent_d[1] = dec_entry;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d  = ST_ONE;
            ent_d[0] = ent_q[1];
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_EMPTY;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_sched.sv
`default_nettype none
// tb_imm_ext_sched -- directed self-checking bench for imm_ext_sched
// Rev 1.0
module tb_imm_ext_sched;

  logic        Clk = 1'b0;
  logic        Rst, Flush, In_valid, Out_ready;
  logic        In_ready, Out_valid;
  logic [31:0] Instruction, Imm_out;
  logic [2:0]  Imm_kind;

  int n_vec = 0;
  int n_err = 0;

  imm_ext_sched dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Flush       (Flush),
    .In_valid    (In_valid),
    .In_ready    (In_ready),
    .Instruction (Instruction),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Imm_out     (Imm_out),
    .Imm_kind    (Imm_kind)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] imm, input logic [2:0] kind);
    chk({tag, ".valid"}, {31'h0, Out_valid}, 32'h1);
    chk({tag, ".imm"},   Imm_out, imm);
    chk({tag, ".kind"},  {29'h0, Imm_kind}, {29'h0, kind});
  endtask

  logic [31:0] s_instr [5];
  logic [31:0] s_imm   [5];
  logic [2:0]  s_kind  [5];

  initial begin
    s_instr[0] = 32'h2000FFFC; s_imm[0] = 32'hFFFFFFFC; s_kind[0] = 3'd1; // addi
    s_instr[1] = 32'h34008001; s_imm[1] = 32'h00008001; s_kind[1] = 3'd2; // ori
    s_instr[2] = 32'h3C001234; s_imm[2] = 32'h12340000; s_kind[2] = 3'd3; // lui
    s_instr[3] = 32'h1000FFFF; s_imm[3] = 32'hFFFFFFFC; s_kind[3] = 3'd4; // beq
    s_instr[4] = 32'h00221820; s_imm[4] = 32'h00000000; s_kind[4] = 3'd0; // add

    Rst = 1'b1; Flush = 1'b0; In_valid = 1'b0; Out_ready = 1'b0; Instruction = 32'h0;
    tick(); tick();
    Rst = 1'b0;
    chk("rst.valid", {31'h0, Out_valid}, 32'h0);
    chk("rst.imm",   Imm_out, 32'h0);
    chk("rst.kind",  {29'h0, Imm_kind}, 32'h0);
    chk("rst.ready", {31'h0, In_ready}, 32'h1);
    tick();
    chk("idle.valid", {31'h0, Out_valid}, 32'h0);

    // Streaming classification with the consumer always ready
    Out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      In_valid = 1'b1; Instruction = s_instr[i];
      tick();
      chk_head($sformatf("stream%0d", i), s_imm[i], s_kind[i]);
      chk($sformatf("stream%0d.ready", i), {31'h0, In_ready}, 32'h1);
    end
    In_valid = 1'b0;
    tick();
    chk("stream.drain", {31'h0, Out_valid}, 32'h0);

    // Backpressure: A, B fill the buffer, C is held by the source
    Out_ready = 1'b0; In_valid = 1'b1; Instruction = 32'h24000001; // A addiu
    tick();
    chk_head("bp.A", 32'h00000001, 3'd1);
    chk("bp.A.ready", {31'h0, In_ready}, 32'h1);
    Instruction = 32'h3000FFFF; // B andi
    tick();
    chk_head("bp.B_head", 32'h00000001, 3'd1);
    chk("bp.B.ready", {31'h0, In_ready}, 32'h0);
    Instruction = 32'h28008000; // C slti
    tick();
    chk_head("bp.C_held", 32'h00000001, 3'd1);
    chk("bp.C.ready", {31'h0, In_ready}, 32'h0);
    Out_ready = 1'b1;
    tick();
    chk_head("bp.deliverB", 32'h0000FFFF, 3'd2);
    chk("bp.deliverB.ready", {31'h0, In_ready}, 32'h1);
    tick();
    chk_head("bp.deliverC", 32'hFFFF8000, 3'd1);
    In_valid = 1'b0;
    tick();
    chk("bp.empty", {31'h0, Out_valid}, 32'h0);

    // Simultaneous push/pop while holding one entry
    Out_ready = 1'b0; In_valid = 1'b1; Instruction = 32'h3C00ABCD; // lui
    tick();
    chk_head("pp.A", 32'hABCD0000, 3'd3);
    Out_ready = 1'b1; Instruction = 32'h14000002; // bne
    tick();
    chk_head("pp.B", 32'h00000008, 3'd4);
    chk("pp.ready", {31'h0, In_ready}, 32'h1);
    In_valid = 1'b0;
    tick();
    chk("pp.empty", {31'h0, Out_valid}, 32'h0);

    // Flush from TWO with a concurrent push
    Out_ready = 1'b0; In_valid = 1'b1; Instruction = 32'h8C000010; // lw
    tick();
    Instruction = 32'h38000F0F; // xori
    tick();
    chk("fl.full", {31'h0, In_ready}, 32'h0);
    Flush = 1'b1; Instruction = 32'h20000005;
    tick();
    Flush = 1'b0; In_valid = 1'b0;
    chk("fl.valid", {31'h0, Out_valid}, 32'h0);
    chk("fl.ready", {31'h0, In_ready}, 32'h1);
    tick();
    chk("fl.notkept", {31'h0, Out_valid}, 32'h0);

    // Reset with Flush while full
    In_valid = 1'b1; Instruction = 32'h2400FFFF;
    tick();
    Instruction = 32'h3400AAAA;
    tick();
    Rst = 1'b1; Flush = 1'b1;
    tick();
    Rst = 1'b0; Flush = 1'b0; In_valid = 1'b0;
    chk("rst2.valid", {31'h0, Out_valid}, 32'h0);
    chk("rst2.imm",   Imm_out, 32'h0);
    chk("rst2.kind",  {29'h0, Imm_kind}, 32'h0);
    chk("rst2.ready", {31'h0, In_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
